// File: rtl/y_md_pkg.sv
`default_nettype none
// ============================================================
// Package  : y_md_pkg
// Purpose  : op/state encodings and sizing helpers for y_mult_div.
// Revision : 1.0
// ============================================================
package y_md_pkg;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/y_mult_div_if.sv
`default_nettype none
// ============================================================
// Interface : y_mult_div_if
// Purpose   : start/busy/done request bus and HI/LO results.
// Revision  : 1.0
// ============================================================
interface y_mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div0, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/y_cond_neg.sv
`default_nettype none
// ============================================================
// Module   : y_cond_neg
// Purpose  : z = neg ? -x : x, as an inverter plus incrementing adder.
// Revision : 1.0
// ============================================================
module y_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] z
);
  assign z = (x ^ {WIDTH{neg}}) + {{(WIDTH-1){1'b0}}, neg};
endmodule
`default_nettype wire

// File: rtl/y_mult_div.sv
`default_nettype none
// ============================================================
// Module   : y_mult_div
// Purpose  : iterative mult/multu/div/divu unit producing HI/LO.
//            Define YMD_EARLY_OUT_EN to end multiplies early once
//            the remaining multiplier magnitude is zero.
// Revision : 1.0
// ============================================================
module y_mult_div
  import y_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  y_mult_div_if.slave md
);
  localparam int CW = cnt_width(WIDTH);
  localparam int W2 = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    aux_q, aux_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_pend_q, div0_pend_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic             op_signed, op_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2-1:0]    fix_prod;
  logic [WIDTH-1:0] fix_quot, fix_rem;

  assign op_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
  assign op_div    = (md.op == MD_DIVU) || (md.op == MD_DIV);

  y_cond_neg #(.WIDTH(WIDTH)) u_mag_a (.neg(op_signed & md.a[WIDTH-1]), .x(md.a), .z(mag_a));
  y_cond_neg #(.WIDTH(WIDTH)) u_mag_b (.neg(op_signed & md.b[WIDTH-1]), .x(md.b), .z(mag_b));

  y_cond_neg #(.WIDTH(W2))    u_fix_prod (.neg(neg_lo_q), .x(acc_q),              .z(fix_prod));
  y_cond_neg #(.WIDTH(WIDTH)) u_fix_quot (.neg(neg_lo_q), .x(acc_q[WIDTH-1:0]),   .z(fix_quot));
  y_cond_neg #(.WIDTH(WIDTH)) u_fix_rem  (.neg(neg_hi_q), .x(acc_q[W2-1:WIDTH]),  .z(fix_rem));

  // Multiply step: accumulate the left-shifting multiplicand for each set multiplier bit.
  logic [W2-1:0]    acc_mul, aux_shl;
  logic [WIDTH-1:0] mplier_shr;
  assign acc_mul    = acc_q + (mplier_q[0] ? aux_q : '0);
  assign aux_shl    = {aux_q[W2-2:0], 1'b0};
  assign mplier_shr = mplier_q >> 1;

  // Restoring divide step on {remainder, quotient}; divisor lives in aux_q low half.
  logic [WIDTH:0]   div_upper, div_diff;
  logic [W2-1:0]    acc_div;
  assign div_upper = acc_q[W2-1:WIDTH-1];
  assign div_diff  = div_upper - {1'b0, aux_q[WIDTH-1:0]};
  assign acc_div   = div_diff[WIDTH] ? {div_upper[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  logic early_done;
`ifdef YMD_EARLY_OUT_EN
  assign early_done = (mplier_shr == '0);
`else
  assign early_done = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    aux_d       = aux_q;
    mplier_d    = mplier_q;
    is_div_d    = is_div_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    div0_pend_d = div0_pend_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    div0_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md.start) begin
          is_div_d    = op_div;
          count_d     = CW'(WIDTH);
          neg_lo_d    = op_signed & (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
          neg_hi_d    = op_signed & md.a[WIDTH-1];
          div0_pend_d = 1'b0;
          mplier_d    = mag_b;
          state_d     = S_RUN;
          if (op_div) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            aux_d = {{WIDTH{1'b0}}, mag_b};
            if (md.b == '0) begin
              div0_pend_d = 1'b1;
              acc_d       = {md.a, {WIDTH{1'b1}}};
              state_d     = S_FIX;
            end
          end else begin
            acc_d = '0;
            aux_d = {{WIDTH{1'b0}}, mag_a};
          end
        end
      end
      S_RUN: begin
        count_d = count_q - CW'(1);
        if (is_div_q) begin
          acc_d = acc_div;
        end else begin
          acc_d    = acc_mul;
          aux_d    = aux_shl;
          mplier_d = mplier_shr;
        end
        if (count_q == CW'(1) || (!is_div_q && early_done)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (div0_pend_q) begin
          hi_d = acc_q[W2-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end else if (is_div_q) begin
          hi_d = fix_rem;
          lo_d = fix_quot;
        end else begin
          hi_d = fix_prod[W2-1:WIDTH];
          lo_d = fix_prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        div0_d  = div0_pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      aux_q       <= '0;
      mplier_q    <= '0;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      div0_pend_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      aux_q       <= aux_d;
      mplier_q    <= mplier_d;
      is_div_q    <= is_div_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      div0_pend_q <= div0_pend_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      div0_q      <= div0_d;
    end
  end

  assign md.busy = (state_q != S_IDLE);
  assign md.done = done_q;
  assign md.div0 = div0_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
`default_nettype wire
